// File: rtl/tc_sram_tiled_pkg.sv
// Shared types and byte-lane helpers for the tiled SRAM; word/byte helpers work on
// fixed maximum widths (DataWidth <= 1024, BeWidth <= 128) and callers zero-extend.
package tc_sram_tiled_pkg;

  localparam int unsigned MaxWidth  = 1024;
  localparam int unsigned MaxBytes  = 128;
  localparam int unsigned MaxWidthW = $clog2(MaxWidth);
  localparam int unsigned MaxBytesW = $clog2(MaxBytes);

  typedef logic [MaxWidth-1:0] word_t;
  typedef logic [MaxBytes-1:0] be_t;

  typedef enum logic {
    IDLE,
    RMW_WR
  } state_e;

  typedef enum logic [1:0] {
    COL_EMPTY,
    COL_FULL,
    COL_PARTIAL
  } col_e;

  function automatic col_e col_partial(input be_t be, input int unsigned nbytes);
    logic any_set;
    logic all_set;
    any_set = 1'b0;
    all_set = 1'b1;
    for (int unsigned i = 0; i < MaxBytes; i++) begin
      if (i < nbytes) begin
        any_set = any_set | be[i[MaxBytesW-1:0]];
        all_set = all_set & be[i[MaxBytesW-1:0]];
      end
    end
    if (!any_set) return COL_EMPTY;
    if (all_set) return COL_FULL;
    return COL_PARTIAL;
  endfunction

  function automatic word_t merge_bytes(input word_t old_w, input word_t new_w,
                                        input be_t be, input int unsigned bw);
    word_t m;
    int unsigned b;
    m = old_w;
    for (int unsigned i = 0; i < MaxWidth; i++) begin
      b = i / bw;
      if (b < MaxBytes && be[b[MaxBytesW-1:0]]) m[i[MaxWidthW-1:0]] = new_w[i[MaxWidthW-1:0]];
    end
    return m;
  endfunction

endpackage

// File: rtl/tc_sram_tiled_tile.sv
// One 1RW full-word macro tile: 1-cycle read latency, output holds the last read.
// No backpressure; behavioural array in simulation, ASAP7 hard macro under SYNTHESIS.
module sram_tile_1rw #(
  parameter int unsigned TileWords = 64,
  parameter int unsigned TileWidth = 64,
  localparam int unsigned Aw = $clog2(TileWords)
) (
  input  logic                 clk_i,
  input  logic                 ce_i,
  input  logic                 we_i,
  input  logic [Aw-1:0]        addr_i,
  input  logic [TileWidth-1:0] wdata_i,
  output logic [TileWidth-1:0] rdata_o
);

`ifdef SYNTHESIS
  asap7_sram_1rw_64x64 u_macro (
    .clk     (clk_i),
    .ce_in   (~ce_i),
    .we_in   (we_i),
    .addr_in (addr_i),
    .wd_in   (wdata_i),
    .rd_out  (rdata_o)
  );
`else
  logic [TileWidth-1:0] mem_q [TileWords];
  logic [TileWidth-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (ce_i) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      else      rdata_q       <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;
`endif

endmodule

// File: rtl/tc_sram_tiled.sv
// Byte-enable SRAM from Rows x Cols full-word tiles; reads return 1 cycle after grant.
// Partial-byte writes take a 2-cycle read-modify-write during which gnt_o is held low.
module tc_sram_tiled
  import tc_sram_tiled_pkg::*;
#(
  parameter int unsigned NumWords  = 256,
  parameter int unsigned DataWidth = 256,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned TileWords = 64,
  parameter int unsigned TileWidth = 64,
  localparam int unsigned AddrWidth = $clog2(NumWords),
  localparam int unsigned BeWidth   = DataWidth / ByteWidth,
  localparam int unsigned Rows      = NumWords / TileWords,
  localparam int unsigned Cols      = DataWidth / TileWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [BeWidth-1:0]   be_i,
  output logic                 rvalid_o,
  output logic [DataWidth-1:0] rdata_o,
  output logic                 oob_o
);

  localparam int unsigned TileAw = $clog2(TileWords);
  localparam int unsigned TileBe = TileWidth / ByteWidth;
  localparam int unsigned RowW   = (AddrWidth > TileAw) ? AddrWidth - TileAw : 1;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic [BeWidth-1:0]   be_q, be_d;
  logic                 rvalid_q, rvalid_d;
  logic                 oob_q, oob_d;
  logic                 rd_oob_q, rd_oob_d;
  logic [RowW-1:0]      rd_row_q, rd_row_d;
  logic [DataWidth-1:0] hold_q, hold_d;

  logic [RowW-1:0]      row_i, row_q, cur_row;
  logic                 in_range;
  logic [BeWidth-1:0]   cur_be;
  logic [Cols-1:0]      col_nonempty, col_part;
  logic                 acc, acc_we;
  logic [Cols-1:0]      col_mask;
  logic [TileAw-1:0]    t_addr;
  logic [DataWidth-1:0] t_wdata;
  logic [Rows-1:0][DataWidth-1:0] row_flat;
  logic [DataWidth-1:0] row_dat;
  logic [DataWidth-1:0] merged;
  word_t                merged_w;

  assign row_i    = RowW'(addr_i >> TileAw);
  assign row_q    = RowW'(addr_q >> TileAw);
  assign in_range = {1'b0, addr_i} < (AddrWidth + 1)'(NumWords);
  assign cur_be   = (state_q == RMW_WR) ? be_q : be_i;
  assign cur_row  = (state_q == RMW_WR) ? row_q : row_i;

  always_comb begin
    col_e k;
    col_nonempty = '0;
    col_part     = '0;
    for (int unsigned c = 0; c < Cols; c++) begin
      k = col_partial(be_t'(cur_be[c*TileBe +: TileBe]), TileBe);
      col_nonempty[c] = (k != COL_EMPTY);
      col_part[c]     = (k == COL_PARTIAL);
    end
  end

  // rd_row_q always names the row of the most recent tile access, so it also
  // selects the old word for the merge while in RMW_WR.
  always_comb begin
    row_dat = '0;
    for (int unsigned r = 0; r < Rows; r++) begin
      if (RowW'(r) == rd_row_q) row_dat = row_flat[r];
    end
  end

  assign merged_w = merge_bytes(word_t'(row_dat), word_t'(wdata_q), be_t'(be_q), ByteWidth);
  assign merged   = merged_w[DataWidth-1:0];

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    rvalid_d = 1'b0;
    oob_d    = 1'b0;
    rd_oob_d = 1'b0;
    rd_row_d = rd_row_q;
    gnt_o    = 1'b0;
    acc      = 1'b0;
    acc_we   = 1'b0;
    col_mask = '0;
    t_addr   = addr_i[TileAw-1:0];
    t_wdata  = wdata_i;
    unique case (state_q)
      IDLE: begin
        gnt_o = req_i;
        if (req_i) begin
          if (!in_range) begin
            oob_d    = 1'b1;
            rvalid_d = !we_i;
            rd_oob_d = 1'b1;
          end else begin
            rd_row_d = row_i;
            if (!we_i) begin
              acc      = 1'b1;
              col_mask = '1;
              rvalid_d = 1'b1;
            end else if (|col_part) begin
              acc      = 1'b1;
              col_mask = '1;
              addr_d   = addr_i;
              wdata_d  = wdata_i;
              be_d     = be_i;
              state_d  = RMW_WR;
            end else begin
              acc      = 1'b1;
              acc_we   = 1'b1;
              col_mask = col_nonempty;
            end
          end
        end
      end
      RMW_WR: begin
        acc      = 1'b1;
        acc_we   = 1'b1;
        col_mask = col_nonempty;
        t_addr   = addr_q[TileAw-1:0];
        t_wdata  = merged;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rvalid_o = rvalid_q;
  assign oob_o    = oob_q;
  assign rdata_o  = rvalid_q ? (rd_oob_q ? '0 : row_dat) : hold_q;
  assign hold_d   = rvalid_q ? rdata_o : hold_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      rvalid_q <= 1'b0;
      oob_q    <= 1'b0;
      rd_oob_q <= 1'b0;
      rd_row_q <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      rvalid_q <= rvalid_d;
      oob_q    <= oob_d;
      rd_oob_q <= rd_oob_d;
      rd_row_q <= rd_row_d;
      hold_q   <= hold_d;
    end
  end

  for (genvar r = 0; r < Rows; r++) begin : g_row
    for (genvar c = 0; c < Cols; c++) begin : g_col
      sram_tile_1rw #(
        .TileWords (TileWords),
        .TileWidth (TileWidth)
      ) u_tile (
        .clk_i   (clk_i),
        .ce_i    (acc && col_mask[c] && (cur_row == RowW'(r))),
        .we_i    (acc_we),
        .addr_i  (t_addr),
        .wdata_i (t_wdata[c*TileWidth +: TileWidth]),
        .rdata_o (row_flat[r][c*TileWidth +: TileWidth])
      );
    end
  end

endmodule

// File: tb/tb_tc_sram_tiled.sv
// Directed bench for tc_sram_tiled: default 4x4 config plus a 192-word config for range checks.
module tb_tc_sram_tiled;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         req1, we1, gnt1, rvalid1, oob1;
  logic [7:0]   addr1;
  logic [255:0] wdata1, rdata1;
  logic [31:0]  be1;
  logic         req2, we2, gnt2, rvalid2, oob2;
  logic [7:0]   addr2;
  logic [255:0] wdata2, rdata2;
  logic [31:0]  be2;

  tc_sram_tiled u_dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req1), .gnt_o(gnt1), .we_i(we1),
    .addr_i(addr1), .wdata_i(wdata1), .be_i(be1), .rvalid_o(rvalid1),
    .rdata_o(rdata1), .oob_o(oob1)
  );

  tc_sram_tiled #(.NumWords(192)) u_dut192 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req2), .gnt_o(gnt2), .we_i(we2),
    .addr_i(addr2), .wdata_i(wdata2), .be_i(be2), .rvalid_o(rvalid2),
    .rdata_o(rdata2), .oob_o(oob2)
  );

  int checks = 0;
  int failures = 0;

  int           s_waits;
  logic         s_rvalid, s_oob;
  logic [255:0] s_rdata, s_pre;

  localparam logic [255:0] V1 = {8{32'h11111111}};
  localparam logic [255:0] V2 = {{7{32'h11111111}}, 32'hAABBCCDD};
  localparam logic [255:0] V3 = {64'h2222222222222222, {5{32'h11111111}}, 32'hAABBCCDD};
  logic [255:0] v4;

  // Called at a negedge; returns at the negedge after the grant edge with outputs sampled.
  task automatic issue(input bit sel, input bit we, input logic [7:0] a,
                       input logic [255:0] d, input logic [31:0] be);
    int w;
    logic g;
    if (sel) begin req2 = 1'b1; we2 = we; addr2 = a; wdata2 = d; be2 = be; end
    else     begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; be1 = be; end
    w = 0;
    #1;
    g = sel ? gnt2 : gnt1;
    while (g !== 1'b1 && w < 8) begin
      @(negedge clk); #1;
      w++;
      g = sel ? gnt2 : gnt1;
    end
    checks++;
    if (g !== 1'b1) begin
      failures++;
      $display("FAIL grant_timeout addr=%h waited=%0d cycles without gnt", a, w);
    end
    s_waits = w;
    s_pre   = sel ? rdata2 : rdata1;
    @(negedge clk);
    s_rvalid = sel ? rvalid2 : rvalid1;
    s_oob    = sel ? oob2 : oob1;
    s_rdata  = sel ? rdata2 : rdata1;
    if (sel) req2 = 1'b0; else req1 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk);
    req1 = 1'b1;
    #1;
    checks++; if (gnt1 !== 1'b1) begin failures++; $display("FAIL reset_gnt_hi got=%b exp=1", gnt1); end
    req1 = 1'b0;
    #1;
    checks++; if (gnt1 !== 1'b0) begin failures++; $display("FAIL reset_gnt_lo got=%b exp=0", gnt1); end
    checks++; if (rvalid1 !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b exp=0", rvalid1); end
    checks++; if (oob1 !== 1'b0) begin failures++; $display("FAIL reset_oob got=%b exp=0", oob1); end
    checks++; if (rdata1 !== 256'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata1); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_write();
    issue(0, 1, 8'h45, V1, 32'hFFFFFFFF);
    checks++; if (s_waits != 0) begin failures++; $display("FAIL full_wr_gnt waits=%0d exp=0", s_waits); end
    checks++; if (s_rvalid !== 1'b0) begin failures++; $display("FAIL full_wr_rvalid got=%b exp=0", s_rvalid); end
    issue(0, 0, 8'h45, '0, '0);
    checks++; if (s_waits != 0) begin failures++; $display("FAIL full_rd_gnt waits=%0d exp=0", s_waits); end
    checks++; if (s_rvalid !== 1'b1) begin failures++; $display("FAIL full_rd_rvalid got=%b exp=1", s_rvalid); end
    checks++; if (s_rdata !== V1) begin failures++; $display("FAIL full_rd_data got=%h exp=%h", s_rdata, V1); end
    @(negedge clk);
    checks++; if (rvalid1 !== 1'b0) begin failures++; $display("FAIL full_rd_rvalid_once got=%b exp=0", rvalid1); end
  endtask

  task automatic test_partial_write();
    issue(0, 1, 8'h45, {{7{32'hFFFFFFFF}}, 32'hAABBCCDD}, 32'h0000000F);
    checks++; if (s_waits != 0) begin failures++; $display("FAIL part_wr_gnt waits=%0d exp=0", s_waits); end
    checks++; if (s_rvalid !== 1'b0) begin failures++; $display("FAIL part_wr_rvalid got=%b exp=0", s_rvalid); end
    issue(0, 0, 8'h45, '0, '0);
    checks++; if (s_waits != 1) begin failures++; $display("FAIL part_stall waits=%0d exp=1", s_waits); end
    checks++; if (s_rdata !== V2) begin failures++; $display("FAIL part_rd_data got=%h exp=%h", s_rdata, V2); end
  endtask

  task automatic test_column_write();
    issue(0, 1, 8'h45, {32{8'h99}}, 32'h00000000);
    checks++; if (s_waits != 0) begin failures++; $display("FAIL be0_gnt waits=%0d exp=0", s_waits); end
    issue(0, 0, 8'h45, '0, '0);
    checks++; if (s_waits != 0) begin failures++; $display("FAIL be0_no_stall waits=%0d exp=0", s_waits); end
    checks++; if (s_rdata !== V2) begin failures++; $display("FAIL be0_rd_data got=%h exp=%h", s_rdata, V2); end
    issue(0, 1, 8'h45, {32{8'h22}}, 32'hFF000000);
    checks++; if (s_waits != 0) begin failures++; $display("FAIL col_wr_gnt waits=%0d exp=0", s_waits); end
    issue(0, 0, 8'h45, '0, '0);
    checks++; if (s_waits != 0) begin failures++; $display("FAIL col_no_stall waits=%0d exp=0", s_waits); end
    checks++; if (s_rdata !== V3) begin failures++; $display("FAIL col_rd_data got=%h exp=%h", s_rdata, V3); end
  endtask

  task automatic test_back_to_back();
    v4 = V3;
    v4[71:64]   = 8'h5A;
    v4[135:128] = 8'h5A;
    issue(0, 1, 8'h45, {32{8'h5A}}, 32'h00010100);
    checks++; if (s_rdata !== V3) begin failures++; $display("FAIL b2b_hold_rmw got=%h exp=%h", s_rdata, V3); end
    checks++; if (s_rvalid !== 1'b0) begin failures++; $display("FAIL b2b_rvalid_rmw got=%b exp=0", s_rvalid); end
    issue(0, 0, 8'h45, '0, '0);
    checks++; if (s_waits != 1) begin failures++; $display("FAIL b2b_grant_delay waits=%0d exp=1", s_waits); end
    checks++; if (s_pre !== V3) begin failures++; $display("FAIL b2b_hold_pre got=%h exp=%h", s_pre, V3); end
    checks++; if (s_rvalid !== 1'b1) begin failures++; $display("FAIL b2b_rvalid got=%b exp=1", s_rvalid); end
    checks++; if (s_rdata !== v4) begin failures++; $display("FAIL b2b_merged got=%h exp=%h", s_rdata, v4); end
  endtask

  task automatic test_reset_in_rmw();
    issue(0, 1, 8'h45, {32{8'hEE}}, 32'h00000001);
    rst_n = 1'b0;
    req1 = 1'b1; we1 = 1'b0;
    #1;
    checks++; if (gnt1 !== 1'b1) begin failures++; $display("FAIL rmw_rst_gnt got=%b exp=1", gnt1); end
    req1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (rvalid1 !== 1'b0) begin failures++; $display("FAIL rmw_rst_rvalid got=%b exp=0", rvalid1); end
    checks++; if (rdata1 !== 256'h0) begin failures++; $display("FAIL rmw_rst_rdata got=%h exp=0", rdata1); end
    issue(0, 0, 8'h45, '0, '0);
    checks++; if (s_rdata !== v4) begin failures++; $display("FAIL rmw_rst_dropped got=%h exp=%h", s_rdata, v4); end
  endtask

  task automatic test_out_of_range();
    logic [255:0] a_dat, b_dat;
    a_dat = {8{32'hA5A50001}};
    b_dat = {8{32'h5A5A0081}};
    issue(1, 1, 8'h01, a_dat, 32'hFFFFFFFF);
    issue(1, 1, 8'h81, b_dat, 32'hFFFFFFFF);
    checks++; if (s_oob !== 1'b0) begin failures++; $display("FAIL oob_inrange_wr got=%b exp=0", s_oob); end
    issue(1, 0, 8'h81, '0, '0);
    checks++; if (s_rdata !== b_dat) begin failures++; $display("FAIL oob_pre_rd got=%h exp=%h", s_rdata, b_dat); end
    issue(1, 0, 8'hC0, '0, '0);
    checks++; if (s_waits != 0) begin failures++; $display("FAIL oob_rd_gnt waits=%0d exp=0", s_waits); end
    checks++; if (s_oob !== 1'b1) begin failures++; $display("FAIL oob_rd_pulse got=%b exp=1", s_oob); end
    checks++; if (s_rvalid !== 1'b1) begin failures++; $display("FAIL oob_rd_rvalid got=%b exp=1", s_rvalid); end
    checks++; if (s_rdata !== 256'h0) begin failures++; $display("FAIL oob_rd_data got=%h exp=0", s_rdata); end
    issue(1, 1, 8'hC1, {8{32'hDEADBEEF}}, 32'hFFFFFFFF);
    checks++; if (s_waits != 0) begin failures++; $display("FAIL oob_wr_gnt waits=%0d exp=0", s_waits); end
    checks++; if (s_oob !== 1'b1) begin failures++; $display("FAIL oob_wr_pulse got=%b exp=1", s_oob); end
    checks++; if (s_rvalid !== 1'b0) begin failures++; $display("FAIL oob_wr_rvalid got=%b exp=0", s_rvalid); end
    issue(1, 0, 8'h01, '0, '0);
    checks++; if (s_oob !== 1'b0) begin failures++; $display("FAIL oob_clear got=%b exp=0", s_oob); end
    checks++; if (s_rdata !== a_dat) begin failures++; $display("FAIL oob_keep_row0 got=%h exp=%h", s_rdata, a_dat); end
    issue(1, 0, 8'h81, '0, '0);
    checks++; if (s_rdata !== b_dat) begin failures++; $display("FAIL oob_keep_row2 got=%h exp=%h", s_rdata, b_dat); end
  endtask

  initial begin
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0; be1 = '0;
    req2 = 1'b0; we2 = 1'b0; addr2 = '0; wdata2 = '0; be2 = '0;
    s_waits = 0; s_rvalid = 1'b0; s_oob = 1'b0; s_rdata = '0; s_pre = '0; v4 = '0;
    test_reset();
    test_full_write();
    test_partial_write();
    test_column_write();
    test_back_to_back();
    test_reset_in_rmw();
    test_out_of_range();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout sim time exceeded limit");
    $fatal(1, "timeout");
  end

endmodule
